// File: rtl/cc4_pkg.sv
// Shared definitions for the CC4 Viterbi decoder: trellis size, generator masks,
// the trellis state type and the expected-symbol helper.
package cc4_pkg;

    localparam int unsigned CC4_NSTATES = 8;
    localparam logic [3:0]  G1 = 4'b1011;
    localparam logic [3:0]  G2 = 4'b1111;

    typedef logic [2:0] state_t;

    // State is {r1,r2,r3}; rebuild the register as r3..r0 to match the masks.
    function automatic logic [1:0] cc4_expected(state_t s, logic b);
        logic [3:0] r;
        r = {s[0], s[1], s[2], b};
        return {^(r & G1), ^(r & G2)};
    endfunction

endpackage

// File: rtl/cc4_acs.sv
// Add-compare-select cell for one next state: picks the cheaper of two predecessors
// and extends its survivor with the input bit that leads into this state.
module cc4_acs
    import cc4_pkg::*;
#(
    parameter int unsigned TB_DEPTH = 16,
    parameter int unsigned PM_W     = 6
) (
    input  logic [PM_W-1:0]     pm0_i,
    input  logic [PM_W-1:0]     pm1_i,
    input  logic [1:0]          bm0_i,
    input  logic [1:0]          bm1_i,
    input  logic [TB_DEPTH-2:0] sv0_i,
    input  logic [TB_DEPTH-2:0] sv1_i,
    input  logic                bit_i,
    output logic [PM_W-1:0]     pm_o,
    output logic                dec_o,
    output logic [TB_DEPTH-1:0] sv_o
);

    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    // Metrics are kept bounded by normalization, so the sums cannot wrap.
    always_comb begin
        cand0 = pm0_i + PM_W'(bm0_i);
        cand1 = pm1_i + PM_W'(bm1_i);
        dec_o = (cand1 < cand0);
        pm_o  = dec_o ? cand1 : cand0;
        sv_o  = dec_o ? {sv1_i, bit_i} : {sv0_i, bit_i};
    end

endmodule

// File: rtl/cc4_viterbi_dec.sv
// Hard-decision register-exchange Viterbi decoder for the rate-1/2, 8-state CC4 code.
// Define CC4_DEC_BEST_STATE_EN to decode from the best-metric state instead of state 0.
module cc4_viterbi_dec
    import cc4_pkg::*;
#(
    parameter int unsigned TB_DEPTH = 16,
    parameter int unsigned PM_W     = 6
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_valid,
    input  logic in1,
    input  logic in2,
    output logic out_valid,
    output logic out
);

    localparam int unsigned     FILL_W  = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

    logic [PM_W-1:0]        pm_q   [CC4_NSTATES];
    logic [PM_W-1:0]        pm_new [CC4_NSTATES];
    logic [PM_W-1:0]        pm_d   [CC4_NSTATES];
    logic [TB_DEPTH-1:0]    sv_q   [CC4_NSTATES];
    logic [TB_DEPTH-1:0]    sv_d   [CC4_NSTATES];
    logic [CC4_NSTATES-1:0] dec;
    logic [CC4_NSTATES-1:0] msb;
    logic [FILL_W-1:0]      fill_q;
    logic [FILL_W-1:0]      fill_d;
    logic                   full;
    state_t                 sel;
    logic                   unused_dec;

    for (genvar ns = 0; ns < CC4_NSTATES; ns++) begin : g_acs
        // Next state {b,x,y} is reached from {x,y,0} and {x,y,1} with input b.
        localparam int P0 = (ns % 4) * 2;
        localparam int P1 = P0 + 1;
        localparam int B  = ns / 4;

        logic [1:0] e0;
        logic [1:0] e1;
        logic [1:0] bm0;
        logic [1:0] bm1;

        assign e0  = cc4_expected(state_t'(P0), 1'(B));
        assign e1  = cc4_expected(state_t'(P1), 1'(B));
        assign bm0 = {1'b0, in1 ^ e0[1]} + {1'b0, in2 ^ e0[0]};
        assign bm1 = {1'b0, in1 ^ e1[1]} + {1'b0, in2 ^ e1[0]};
        assign msb[ns] = pm_new[ns][PM_W-1];

        cc4_acs #(
            .TB_DEPTH (TB_DEPTH),
            .PM_W     (PM_W)
        ) u_acs (
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .sv0_i (sv_q[P0][TB_DEPTH-2:0]),
            .sv1_i (sv_q[P1][TB_DEPTH-2:0]),
            .bit_i (1'(B)),
            .pm_o  (pm_new[ns]),
            .dec_o (dec[ns]),
            .sv_o  (sv_d[ns])
        );
    end

    assign unused_dec = ^dec;
    assign full       = (fill_q == FILL_W'(TB_DEPTH));

    always_comb begin
        for (int i = 0; i < CC4_NSTATES; i++) begin
            pm_d[i] = pm_new[i];
            if (&msb) begin
                pm_d[i][PM_W-1] = 1'b0;
            end
        end
        fill_d = full ? fill_q : fill_q + 1'b1;
    end

`ifdef CC4_DEC_BEST_STATE_EN
    logic [PM_W-1:0] best;

    always_comb begin
        sel  = '0;
        best = pm_new[0];
        for (int i = 1; i < CC4_NSTATES; i++) begin
            if (pm_new[i] < best) begin
                best = pm_new[i];
                sel  = state_t'(i);
            end
        end
    end
`else
    assign sel = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CC4_NSTATES; i++) begin
                pm_q[i] <= (i == 0) ? '0 : PM_INIT;
                sv_q[i] <= '0;
            end
            fill_q    <= '0;
            out_valid <= 1'b0;
            out       <= 1'b0;
        end else if (in_valid) begin
            for (int i = 0; i < CC4_NSTATES; i++) begin
                pm_q[i] <= pm_d[i];
                sv_q[i] <= sv_d[i];
            end
            fill_q    <= fill_d;
            out_valid <= full;
            // Oldest bit of the pre-update survivor belongs to symbol n-TB_DEPTH.
            out       <= sv_q[sel][TB_DEPTH-1];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
